// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types, latency defaults and forwarding helpers for hazard_ctrl
package hazard_pkg;

    localparam int MULT_LAT_DEF = 4;
    localparam int DIV_LAT_DEF  = 32;
    localparam int CNT_W_DEF    = 6;

    // Enum values coincide with the execute-stage select encoding.
    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_WB = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    localparam logic [1:0] FWD_E_RF = 2'b00;
    localparam logic [1:0] FWD_E_WB = 2'b01;
    localparam logic [1:0] FWD_E_M  = 2'b10;
    localparam logic [1:0] FWD_D_RF = 2'b00;
    localparam logic [1:0] FWD_D_M  = 2'b01;
    localparam logic [1:0] FWD_D_WB = 2'b10;

    typedef enum logic {
        MD_IDLE,
        MD_BUSY
    } md_state_t;

    function automatic fwd_sel_t fwd_pick(input logic [4:0] src,
                                          input logic [4:0] wreg_m,  input logic rw_m,
                                          input logic [4:0] wreg_wb, input logic rw_wb);
        if (src == 5'd0)                   return FWD_RF;
        else if (rw_m && wreg_m == src)    return FWD_M;
        else if (rw_wb && wreg_wb == src)  return FWD_WB;
        else                               return FWD_RF;
    endfunction

    function automatic logic [1:0] enc_e(input fwd_sel_t sel);
        case (sel)
            FWD_M:   return FWD_E_M;
            FWD_WB:  return FWD_E_WB;
            default: return FWD_E_RF;
        endcase
    endfunction

    function automatic logic [1:0] enc_d(input fwd_sel_t sel);
        case (sel)
            FWD_M:   return FWD_D_M;
            FWD_WB:  return FWD_D_WB;
            default: return FWD_D_RF;
        endcase
    endfunction

endpackage

// File: rtl/md_seq.sv
// rtl/md_seq.sv - multiply/divide occupancy sequencer (IDLE/BUSY FSM with down-counter)
module md_seq
    import hazard_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic issue,
    input  logic is_div,
    output logic busy,
    output logic done
);

    md_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] lat;

    assign lat = is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);

    // busy/done are registered; done is pre-computed from the count one edge ahead.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= MD_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (issue) begin
                        state <= MD_BUSY;
                        cnt   <= lat;
                        busy  <= 1'b1;
                        done  <= (lat == CNT_W'(1));
                    end
                end
                MD_BUSY: begin
                    cnt  <= cnt - 1'b1;
                    done <= (cnt == CNT_W'(2));
                    if (cnt == CNT_W'(1)) begin
                        state <= MD_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= MD_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - MIPS pipeline forwarding/stall/flush control; HAZARD_STATS_EN adds stall/flush counters
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs_D,
    input  logic [4:0]  rt_D,
    input  logic [4:0]  rs_E,
    input  logic [4:0]  rt_E,
    input  logic [4:0]  writereg_E,
    input  logic [4:0]  writereg_M,
    input  logic [4:0]  writereg_WB,
    input  logic        regwrite_E,
    input  logic        regwrite_M,
    input  logic        regwrite_WB,
    input  logic        memtoreg_E,
    input  logic        memtoreg_M,
    input  logic        branch_D,
    input  logic        pcsrc_D,
    input  logic        md_op_D,
    input  logic        md_div_D,
    input  logic        mfhilo_D,
    output logic        stall_F,
    output logic        stall_D,
    output logic        flush_D,
    output logic        flush_E,
    output logic [1:0]  forwardA_D,
    output logic [1:0]  forwardB_D,
    output logic [1:0]  forwardA_E,
    output logic [1:0]  forwardB_E,
    output logic        md_busy,
    output logic        md_done
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_cycles
`endif
);

    logic hit_e_d;
    logic hit_m_d;
    logic lw_stall;
    logic br_stall;
    logic md_stall;
    logic any_stall;

    assign forwardA_E = enc_e(fwd_pick(rs_E, writereg_M, regwrite_M, writereg_WB, regwrite_WB));
    assign forwardB_E = enc_e(fwd_pick(rt_E, writereg_M, regwrite_M, writereg_WB, regwrite_WB));
    assign forwardA_D = enc_d(fwd_pick(rs_D, writereg_M, regwrite_M, writereg_WB, regwrite_WB));
    assign forwardB_D = enc_d(fwd_pick(rt_D, writereg_M, regwrite_M, writereg_WB, regwrite_WB));

    assign hit_e_d = (writereg_E != 5'd0) && (writereg_E == rs_D || writereg_E == rt_D);
    assign hit_m_d = (writereg_M != 5'd0) && (writereg_M == rs_D || writereg_M == rt_D);

    // Branches compare in decode, so any in-flight producer in E, or a load still in M, must drain first.
    assign lw_stall  = memtoreg_E && hit_e_d;
    assign br_stall  = branch_D && ((regwrite_E && hit_e_d) || (memtoreg_M && hit_m_d));
    assign md_stall  = md_busy && (mfhilo_D || md_op_D);
    assign any_stall = lw_stall || br_stall || md_stall;

    assign stall_F = any_stall;
    assign stall_D = any_stall;
    assign flush_E = any_stall;
    assign flush_D = pcsrc_D && !any_stall;

    md_seq #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT),
        .CNT_W    (CNT_W)
    ) u_md_seq (
        .clk    (clk),
        .reset  (reset),
        .issue  (md_op_D && !any_stall),
        .is_div (md_div_D),
        .busy   (md_busy),
        .done   (md_done)
    );

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_cycles <= '0;
        end else begin
            if (stall_D)
                stall_cycles <= stall_cycles + 32'd1;
            if (flush_D || flush_E)
                flush_cycles <= flush_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed vector bench for hazard_ctrl (optionally with HAZARD_STATS_EN)
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs_D, rt_D, rs_E, rt_E, writereg_E, writereg_M, writereg_WB;
    logic       regwrite_E, regwrite_M, regwrite_WB, memtoreg_E, memtoreg_M;
    logic       branch_D, pcsrc_D, md_op_D, md_div_D, mfhilo_D;
    logic       stall_F, stall_D, flush_D, flush_E, md_busy, md_done;
    logic [1:0] forwardA_D, forwardB_D, forwardA_E, forwardB_E;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles, flush_cycles;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .rs_D        (rs_D),
        .rt_D        (rt_D),
        .rs_E        (rs_E),
        .rt_E        (rt_E),
        .writereg_E  (writereg_E),
        .writereg_M  (writereg_M),
        .writereg_WB (writereg_WB),
        .regwrite_E  (regwrite_E),
        .regwrite_M  (regwrite_M),
        .regwrite_WB (regwrite_WB),
        .memtoreg_E  (memtoreg_E),
        .memtoreg_M  (memtoreg_M),
        .branch_D    (branch_D),
        .pcsrc_D     (pcsrc_D),
        .md_op_D     (md_op_D),
        .md_div_D    (md_div_D),
        .mfhilo_D    (mfhilo_D),
        .stall_F     (stall_F),
        .stall_D     (stall_D),
        .flush_D     (flush_D),
        .flush_E     (flush_E),
        .forwardA_D  (forwardA_D),
        .forwardB_D  (forwardB_D),
        .forwardA_E  (forwardA_E),
        .forwardB_E  (forwardB_E),
        .md_busy     (md_busy),
        .md_done     (md_done)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_cycles (flush_cycles)
`endif
    );

    typedef struct {
        logic [4:0] rs_d, rt_d, rs_e, rt_e, w_e, w_m, w_wb;
        logic       rw_e, rw_m, rw_wb, mt_e, mt_m, br, pc;
        logic       stall, fl_d;
        logic [1:0] a_d, b_d, a_e, b_e;
    } vec_t;

    vec_t tv [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        rs_D = 5'd0; rt_D = 5'd0; rs_E = 5'd0; rt_E = 5'd0;
        writereg_E = 5'd0; writereg_M = 5'd0; writereg_WB = 5'd0;
        regwrite_E = 1'b0; regwrite_M = 1'b0; regwrite_WB = 1'b0;
        memtoreg_E = 1'b0; memtoreg_M = 1'b0;
        branch_D = 1'b0; pcsrc_D = 1'b0;
        md_op_D = 1'b0; md_div_D = 1'b0; mfhilo_D = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        rs_D = v.rs_d; rt_D = v.rt_d; rs_E = v.rs_e; rt_E = v.rt_e;
        writereg_E = v.w_e; writereg_M = v.w_m; writereg_WB = v.w_wb;
        regwrite_E = v.rw_e; regwrite_M = v.rw_m; regwrite_WB = v.rw_wb;
        memtoreg_E = v.mt_e; memtoreg_M = v.mt_m;
        branch_D = v.br; pcsrc_D = v.pc;
        md_op_D = 1'b0; md_div_D = 1'b0; mfhilo_D = 1'b0;
    endtask

    initial begin
        //             rs_d   rt_d   rs_e   rt_e   w_e    w_m    w_wb  rwE  rwM  rwWB mtE  mtM  br   pc   stall flD  aD     bD     aE     bE
        tv[0]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0, 2'b00,2'b00,2'b00,2'b00};
        tv[1]  = '{5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 5'd3, 5'd3, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0, 2'b00,2'b00,2'b10,2'b00};
        tv[2]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0, 2'b00,2'b00,2'b00,2'b00};
        tv[3]  = '{5'd0, 5'd0, 5'd4, 5'd0, 5'd0, 5'd9, 5'd4, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0, 2'b00,2'b00,2'b01,2'b00};
        tv[4]  = '{5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0, 2'b00,2'b00,2'b00,2'b00};
        tv[5]  = '{5'd0, 5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0, 2'b00,2'b00,2'b00,2'b01};
        tv[6]  = '{5'd0, 5'd0, 5'd6, 5'd0, 5'd0, 5'd6, 5'd6, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0, 2'b00,2'b00,2'b01,2'b00};
        tv[7]  = '{5'd8, 5'd9, 5'd8, 5'd9, 5'd0, 5'd8, 5'd9, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0, 2'b01,2'b10,2'b10,2'b01};
        tv[8]  = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1, 1'b1,1'b0, 2'b00,2'b00,2'b00,2'b00};
        tv[9]  = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 1'b0,1'b1,1'b0,1'b0,1'b1,1'b1,1'b1, 1'b1,1'b0, 2'b01,2'b00,2'b00,2'b00};
        tv[10] = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd7, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b1, 1'b0,1'b1, 2'b10,2'b00,2'b00,2'b00};
        tv[11] = '{5'd2, 5'd3, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b0, 2'b00,2'b00,2'b00,2'b00};
        tv[12] = '{5'd2, 5'd3, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0, 2'b00,2'b00,2'b00,2'b00};
        tv[13] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1, 1'b0,1'b1, 2'b00,2'b00,2'b00,2'b00};
        tv[14] = '{5'd4, 5'd0, 5'd0, 5'd0, 5'd0, 5'd4, 5'd0, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0, 2'b01,2'b00,2'b00,2'b00};
        tv[15] = '{5'd5, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0, 2'b00,2'b00,2'b00,2'b00};

        set_idle();
        reset = 1'b1;
        tick();
        tick();
        check("reset_md_busy", {31'd0, md_busy}, 32'd0);
        check("reset_md_done", {31'd0, md_done}, 32'd0);
        check("reset_stall_F", {31'd0, stall_F}, 32'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 16; i++) begin
            apply(tv[i]);
            #1;
            check($sformatf("vec%0d", i),
                  {20'd0, stall_F, stall_D, flush_E, flush_D, forwardA_D, forwardB_D, forwardA_E, forwardB_E},
                  {20'd0, tv[i].stall, tv[i].stall, tv[i].stall, tv[i].fl_d, tv[i].a_d, tv[i].b_d, tv[i].a_e, tv[i].b_e});
            tick();
        end

        // div followed by a dependent mflo held in decode
        set_idle();
        md_op_D = 1'b1; md_div_D = 1'b1;
        #1;
        check("div_issue_no_stall", {31'd0, stall_D}, 32'd0);
        tick();
        md_op_D = 1'b0; md_div_D = 1'b0; mfhilo_D = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            #1;
            check($sformatf("div_cyc%0d", i), {29'd0, md_busy, md_done, stall_D},
                  {29'd0, 1'b1, (i == 32), 1'b1});
            tick();
        end
        #1;
        check("div_after", {30'd0, md_busy, stall_D}, 32'd0);
        mfhilo_D = 1'b0;

        // mult interrupted by reset in its second busy cycle
        md_op_D = 1'b1;
        #1;
        check("mult_issue", {31'd0, stall_D}, 32'd0);
        tick();
        md_op_D = 1'b0;
        #1;
        check("mult_busy1", {31'd0, md_busy}, 32'd1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        md_op_D = 1'b1;
        #1;
        check("mult_post_reset", {29'd0, md_busy, md_done, stall_D}, 32'd0);
        tick();

        // back-to-back mult: second op waits in decode until the first completes
        for (int i = 1; i <= 4; i++) begin
            #1;
            check($sformatf("b2b_cyc%0d", i), {29'd0, md_busy, md_done, stall_D},
                  {29'd0, 1'b1, (i == 4), 1'b1});
            tick();
        end
        #1;
        check("b2b_reissue", {30'd0, md_busy, stall_D}, 32'd0);
        tick();
        md_op_D = 1'b0;
        #1;
        check("b2b_reload", {31'd0, md_busy}, 32'd1);
        for (int i = 0; i < 4; i++) tick();

        // issue coinciding with a taken branch still starts the unit
        md_op_D = 1'b1; pcsrc_D = 1'b1;
        #1;
        check("md_pcsrc_flush", {31'd0, flush_D}, 32'd1);
        tick();
        md_op_D = 1'b0; pcsrc_D = 1'b0;
        #1;
        check("md_pcsrc_busy", {31'd0, md_busy}, 32'd1);
        for (int i = 0; i < 4; i++) tick();

`ifdef HAZARD_STATS_EN
        set_idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        apply(tv[4]);
        tick();
        set_idle();
        pcsrc_D = 1'b1;
        tick();
        set_idle();
        #1;
        check("stall_cycles", stall_cycles, 32'd1);
        check("flush_cycles", flush_cycles, 32'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
